// File: rtl/month_year_counter.sv
// month_year_counter
//   Holds the calendar month (1-12) and a two-digit year offset (0-99 from
//   YEAR_BASE). Advances on the rising edge of month_enable, carries month
//   into year, flags leap years, reports the length of the current month and
//   drives BCD digits for the display mux.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   month_enable          month-advance request (pulse or level; edge used)
//   manual_set            load set_month / set_year this cycle (validated)
//   set_month, set_year   values to load, binary
//   month, year           current month 1-12, year offset 0-99
//   leap_year             current year is a leap year
//   days_in_month         last valid day of the current month (28-31)
//   year_pulse            one-cycle strobe on December -> January
//   century_pulse         one-cycle strobe on year 99 -> 0
//   month_tens/ones       BCD digits of month
//   year_tens/ones        BCD digits of year
module month_year_counter #(
  parameter int YEAR_BASE   = 2000,
  parameter int RESET_MONTH = 1,
  parameter int RESET_YEAR  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       month_enable,
  input  logic       manual_set,
  input  logic [3:0] set_month,
  input  logic [6:0] set_year,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       leap_year,
  output logic [4:0] days_in_month,
  output logic       year_pulse,
  output logic       century_pulse,
  output logic [3:0] month_tens,
  output logic [3:0] month_ones,
  output logic [3:0] year_tens,
  output logic [3:0] year_ones
);

  localparam logic [3:0] RST_MONTH = 4'(RESET_MONTH);
  localparam logic [6:0] RST_YEAR  = 7'(RESET_YEAR);
  // YEAR_BASE is a multiple of 400 in practice, so this is 0 and the leap
  // test reduces to year%4==0; kept general for the low two bits.
  localparam logic [1:0] BASE_MOD4 = 2'(YEAR_BASE % 4);

  logic [3:0] month_q, month_d;
  logic [6:0] year_q, year_d;
  logic       en_prev_q, en_prev_d;
  logic       year_pulse_q, year_pulse_d;
  logic       century_pulse_q, century_pulse_d;
  logic       adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      month_q         <= RST_MONTH;
      year_q          <= RST_YEAR;
      en_prev_q       <= 1'b0;
      year_pulse_q    <= 1'b0;
      century_pulse_q <= 1'b0;
    end else begin
      month_q         <= month_d;
      year_q          <= year_d;
      en_prev_q       <= en_prev_d;
      year_pulse_q    <= year_pulse_d;
      century_pulse_q <= century_pulse_d;
    end
  end

  always_comb begin
    // Edge detector tracks the enable even during a manual set, so a level
    // held across the set does not produce an advance afterwards.
    en_prev_d       = month_enable;
    adv             = month_enable & ~en_prev_q;
    month_d         = month_q;
    year_d          = year_q;
    year_pulse_d    = 1'b0;
    century_pulse_d = 1'b0;
    if (manual_set) begin
      if (set_month >= 4'd1 && set_month <= 4'd12) month_d = set_month;
      if (set_year <= 7'd99)                       year_d  = set_year;
    end else if (adv) begin
      if (month_q == 4'd12) begin
        month_d      = 4'd1;
        year_pulse_d = 1'b1;
        if (year_q >= 7'd99) begin
          year_d          = 7'd0;
          century_pulse_d = (year_q == 7'd99);
        end else begin
          year_d = year_q + 7'd1;
        end
      end else if (month_q == 4'd0 || month_q > 4'd12) begin
        // Recover an illegal month without touching the year.
        month_d = 4'd1;
      end else begin
        month_d = month_q + 4'd1;
      end
    end
  end

  logic [1:0] leap_sum;
  logic [6:0] year_tens_w;
  logic [6:0] year_ones_w;

  always_comb begin
    leap_sum  = year_q[1:0] + BASE_MOD4;
    leap_year = (leap_sum == 2'd0);
    case (month_q)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = leap_year ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
    month_tens  = month_q / 4'd10;
    month_ones  = month_q % 4'd10;
    year_tens_w = year_q / 7'd10;
    year_ones_w = year_q % 7'd10;
    year_tens   = year_tens_w[3:0];
    year_ones   = year_ones_w[3:0];
  end

  assign month         = month_q;
  assign year          = year_q;
  assign year_pulse    = year_pulse_q;
  assign century_pulse = century_pulse_q;

endmodule
